// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
module dcache_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    input  logic [3:0]               cpu_be,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              cnt;
    logic [SETS-1:0]         valid;
    logic [TAG_W-1:0]        tag_mem  [SETS];
    logic [DATA_WIDTH-1:0]   data_mem [SETS][4];
    logic [TAG_W-1:0]        fill_tag;
    logic [IDX_W-1:0]        fill_idx;

    logic [1:0]              addr_off;
    logic [IDX_W-1:0]        addr_idx;
    logic [TAG_W-1:0]        addr_tag;
    logic                    hit;
    logic                    miss_start;
    logic                    unused_addr_bits;

    assign addr_off         = cpu_addr[3:2];
    assign addr_idx         = cpu_addr[4 +: IDX_W];
    assign addr_tag         = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit        = cpu_req & valid[addr_idx] & (tag_mem[addr_idx] == addr_tag);
    assign miss_start = (state == IDLE) & cpu_req & ~cpu_we & ~hit;
    assign cpu_rdata  = data_mem[addr_idx][addr_off];

    // Next-state and memory-side outputs; everything defaults to idle/zero
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        stall      = 1'b1;
                        state_next = WRITE;
                    end else if (!hit) begin
                        stall      = 1'b1;
                        state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {fill_tag, fill_idx, cnt, 2'b00};
                if (mem_ack && cnt == 2'd3) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                mem_wdata = cpu_wdata;
                mem_be    = cpu_be;
                stall     = ~mem_ack;
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, refill word counter and valid bits; reset wins over any ack
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            valid <= '0;
        end else begin
            state <= state_next;
            if (miss_start) begin
                cnt             <= 2'd0;
                valid[addr_idx] <= 1'b0;
            end
            if (state == REFILL && mem_ack) begin
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    valid[fill_idx] <= 1'b1;
                end
            end
        end
    end

    // Tag/data arrays and refill target latch; never cleared, writes blocked in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            if (miss_start) begin
                fill_tag <= addr_tag;
                fill_idx <= addr_idx;
            end
            if (state == REFILL && mem_ack) begin
                data_mem[fill_idx][cnt] <= mem_rdata;
                if (cnt == 2'd3) begin
                    tag_mem[fill_idx] <= fill_tag;
                end
            end
            if (state == WRITE && mem_ack && hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (cpu_be[b]) begin
                        data_mem[addr_idx][addr_off][8*b +: 8] <= cpu_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_exp_t;

    typedef struct packed {
        logic        is_load;
        logic [31:0] rdata;
        logic [7:0]  stalls;
    } cpu_exp_t;

    mem_exp_t exp_mem[$];
    cpu_exp_t exp_cpu[$];

    logic [31:0] mem_model [1024];

    dcache_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory acks on the first request cycle
    assign mem_ack   = mem_req;
    assign mem_rdata = mem_req ? mem_model[mem_addr[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (rst && mem_req && mem_we && mem_ack) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem_model[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Monitor: pops expected memory transactions and CPU completions
    always @(negedge clk) begin
        mem_exp_t m;
        cpu_exp_t c;
        if (!rst) begin
            stall_cnt = 0;
        end else begin
            if (mem_req && mem_ack) begin
                tests++;
                if (exp_mem.size() == 0) begin
                    fails++;
                    $display("FAIL mem_unexpected we=%0b addr=%h required none", mem_we, mem_addr);
                end else begin
                    m = exp_mem.pop_front();
                    if (mem_we !== m.we || mem_addr !== m.addr ||
                        (m.we && (mem_wdata !== m.wdata || mem_be !== m.be))) begin
                        fails++;
                        $display("FAIL mem_txn got we=%0b addr=%h wdata=%h be=%b required we=%0b addr=%h wdata=%h be=%b",
                                 mem_we, mem_addr, mem_wdata, mem_be, m.we, m.addr, m.wdata, m.be);
                    end
                end
            end
            if (cpu_req) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    tests++;
                    if (exp_cpu.size() == 0) begin
                        fails++;
                        $display("FAIL cpu_unexpected addr=%h required none", cpu_addr);
                    end else begin
                        c = exp_cpu.pop_front();
                        if (stall_cnt != int'(c.stalls) || (c.is_load && cpu_rdata !== c.rdata)) begin
                            fails++;
                            $display("FAIL cpu_done addr=%h got stalls=%0d rdata=%h required stalls=%0d rdata=%h",
                                     cpu_addr, stall_cnt, cpu_rdata, c.stalls, c.rdata);
                        end
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic push_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b0, base + 32'(4*i), 32'h0, 4'h0});
    endtask

    task automatic push_cpu(input logic is_load, input logic [31:0] rdata, input logic [7:0] stalls);
        exp_cpu.push_back('{is_load, rdata, stalls});
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
        int n;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        n = 0;
        @(negedge clk);
        while (stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            tests++;
            fails++;
            $display("FAIL req_timeout addr=%h got stall=1 required 0", addr);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'hB000_0000 | 32'(i);
        mem_model[4] = 32'h0000_00A0;
        mem_model[5] = 32'h0000_00A1;
        mem_model[6] = 32'h0000_00A2;
        mem_model[7] = 32'h0000_00A3;

        // Reset state
        @(posedge clk); #1;
        check("rst_stall",     {31'h0, stall},   32'h0);
        check("rst_mem_req",   {31'h0, mem_req}, 32'h0);
        check("rst_mem_we",    {31'h0, mem_we},  32'h0);
        check("rst_mem_addr",  mem_addr,         32'h0);
        check("rst_mem_wdata", mem_wdata,        32'h0);
        check("rst_mem_be",    {28'h0, mem_be},  32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Load miss with critical word at offset 2
        push_refill(32'h10);
        push_cpu(1'b1, 32'h0000_00A2, 8'd5);
        do_req(1'b0, 32'h18, 32'h0, 4'h0);

        // Load hit in the same line
        push_cpu(1'b1, 32'h0000_00A1, 8'd0);
        do_req(1'b0, 32'h14, 32'h0, 4'h0);

        // Store hit, byte lane 1
        exp_mem.push_back('{1'b1, 32'h14, 32'h0000_5500, 4'b0010});
        push_cpu(1'b0, 32'h0, 8'd1);
        do_req(1'b1, 32'h14, 32'h0000_5500, 4'b0010);

        push_cpu(1'b1, 32'h0000_55A1, 8'd0);
        do_req(1'b0, 32'h14, 32'h0, 4'h0);

        // Store miss does not allocate
        exp_mem.push_back('{1'b1, 32'h200, 32'hDEAD_BEEF, 4'b1111});
        push_cpu(1'b0, 32'h0, 8'd1);
        do_req(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b1111);

        push_refill(32'h200);
        push_cpu(1'b1, 32'hDEAD_BEEF, 8'd5);
        do_req(1'b0, 32'h200, 32'h0, 4'h0);

        // Reset after the second refill ack
        exp_mem.push_back('{1'b0, 32'h30, 32'h0, 4'h0});
        exp_mem.push_back('{1'b0, 32'h34, 32'h0, 4'h0});
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        check("midrst_stall",   {31'h0, stall},   32'h0);

        push_refill(32'h30);
        push_cpu(1'b1, 32'hB000_000C, 8'd5);
        do_req(1'b0, 32'h30, 32'h0, 4'h0);

        // Conflict misses on index 1
        apply_reset();
        push_refill(32'h10);
        push_cpu(1'b1, 32'h0000_00A0, 8'd5);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        push_refill(32'h90);
        push_cpu(1'b1, 32'hB000_0024, 8'd5);
        do_req(1'b0, 32'h90, 32'h0, 4'h0);
        push_refill(32'h10);
        push_cpu(1'b1, 32'h0000_00A0, 8'd5);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);

        repeat (3) @(posedge clk);
        check("exp_mem_left", 32'(exp_mem.size()), 32'h0);
        check("exp_cpu_left", 32'(exp_cpu.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
